fxp_to_fp_block: RTL and testbench

//  Converts a stream of unsigned fixed-point values (exp-stage results) back to

---
 rtl/fxp_to_fp_block.sv | 143 ++++++++++++++
 tb/tb_fxp_to_fp_block.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_to_fp_block.sv
// -----------------------------------------------------------------------------
// fxp_to_fp_block
//   Buffers a vector of unsigned fixed-point words (format Q(data_size-frac_bits)
//   .frac_bits) and converts them one by one to IEEE-754 single precision.
//   Results leave through a valid/ready handshake. Once number_of_data results
//   have been delivered, fp_done_o is raised and stays set until reset.
//
// Ports
//   clock_i           in   1          rising-edge clock
//   reset_i           in   1          synchronous reset, active-high
//   fxp_data_i        in   data_size  unsigned fixed-point input value
//   fxp_data_valid_i  in   1          input word valid (no backpressure)
//   fp_data_ready_i   in   1          downstream ready for fp_data_o
//   fp_data_valid_o   out  1          fp_data_o valid
//   fp_data_o         out  data_size  FP32 result
//   fp_done_o         out  1          all results delivered (sticky)
//   overflow_o        out  1          input arrived while buffer full (sticky)
// -----------------------------------------------------------------------------
module fxp_to_fp_block #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int frac_bits      = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [data_size-1:0] fxp_data_i,
  input  logic                 fxp_data_valid_i,
  input  logic                 fp_data_ready_i,
  output logic                 fp_data_valid_o,
  output logic [data_size-1:0] fp_data_o,
  output logic                 fp_done_o,
  output logic                 overflow_o
);

  localparam int CNT_W = $clog2(number_of_data + 1);
  localparam int IDX_W = (number_of_data > 1) ? $clog2(number_of_data) : 1;
  localparam int P_W   = $clog2(data_size);

  localparam logic [CNT_W-1:0] N_C = CNT_W'(number_of_data);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOD  = 2'd1;
  localparam logic [1:0] PACK = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [data_size-1:0] buf_mem [number_of_data];
  logic [CNT_W-1:0]     wr_cnt;
  logic [CNT_W-1:0]     rd_cnt;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic [1:0]           state;

  logic [data_size-1:0] x_p0;
  logic [P_W-1:0]       p_p0;
  logic                 z_p0;

  assign wr_idx = wr_cnt[IDX_W-1:0];
  assign rd_idx = rd_cnt[IDX_W-1:0];

  // Index of the highest set bit; 0 when x is zero (zero flag handled apart).
  function automatic logic [P_W-1:0] msb_index(input logic [data_size-1:0] x);
    logic [P_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < data_size; i++) begin
      if (x[i]) idx = P_W'(i);
    end
    return idx;
  endfunction

  // Pack into FP32. The leading one at bit p becomes the hidden bit; shifting
  // {x, 23 zeros} right by p lands bit p at position 23, so bits [22:0] are the
  // fraction bits below the leading one, left-aligned and truncated.
  function automatic logic [data_size-1:0] to_fp32(input logic [data_size-1:0] x,
                                                   input logic [P_W-1:0]       p,
                                                   input logic                 z);
    logic [data_size+22:0] ext;
    logic [7:0]            e;
    logic [22:0]           m;
    ext = {x, 23'b0} >> p;
    m   = ext[22:0];
    e   = 8'(127 + int'(p) - frac_bits);
    if (z) return '0;
    return data_size'({1'b0, e, m});
  endfunction

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      state           <= IDLE;
      fp_data_valid_o <= 1'b0;
      fp_data_o       <= '0;
      fp_done_o       <= 1'b0;
      overflow_o      <= 1'b0;
      x_p0            <= '0;
      p_p0            <= '0;
      z_p0            <= 1'b0;
      for (int i = 0; i < number_of_data; i++) buf_mem[i] <= '0;
    end else begin
      // Input side: accept every valid word until the store is full.
      if (fxp_data_valid_i) begin
        if (wr_cnt < N_C) begin
          buf_mem[wr_idx] <= fxp_data_i;
          wr_cnt          <= wr_cnt + 1'b1;
        end else begin
          overflow_o <= 1'b1;
        end
      end

      // rd_cnt reaches number_of_data on the final handshake edge; done follows.
      if (rd_cnt == N_C) fp_done_o <= 1'b1;

      case (state)
        IDLE: begin
          // rd_cnt < wr_cnt is false once every result is out, so the FSM parks here.
          if (rd_cnt < wr_cnt) state <= LOD;
        end
        // Stage p0: fetch word, leading-one detect.
        LOD: begin
          x_p0  <= buf_mem[rd_idx];
          p_p0  <= msb_index(buf_mem[rd_idx]);
          z_p0  <= (buf_mem[rd_idx] == '0);
          state <= PACK;
        end
        // Stage p1: assemble FP32 word into the output register.
        PACK: begin
          fp_data_o       <= to_fp32(x_p0, p_p0, z_p0);
          fp_data_valid_o <= 1'b1;
          state           <= OUT;
        end
        OUT: begin
          if (fp_data_ready_i) begin
            fp_data_valid_o <= 1'b0;
            rd_cnt          <= rd_cnt + 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_to_fp_block.sv
module tb_fxp_to_fp_block;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [31:0] fxp_data_i;
  logic        fxp_data_valid_i;
  logic        fp_data_ready_i;
  logic        fp_data_valid_o;
  logic [31:0] fp_data_o;
  logic        fp_done_o;
  logic        overflow_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] vec     [0:10];
  logic [31:0] exp_vec [0:10];

  fxp_to_fp_block #(.data_size(32), .number_of_data(10), .frac_bits(16)) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .fxp_data_i       (fxp_data_i),
    .fxp_data_valid_i (fxp_data_valid_i),
    .fp_data_ready_i  (fp_data_ready_i),
    .fp_data_valid_o  (fp_data_valid_o),
    .fp_data_o        (fp_data_o),
    .fp_done_o        (fp_done_o),
    .overflow_o       (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  // All tasks start and end on a falling edge.
  task automatic do_reset();
    reset_i          = 1'b1;
    fxp_data_valid_i = 1'b0;
    fxp_data_i       = 32'h0;
    fp_data_ready_i  = 1'b1;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  // Writes vec[0..n-1] on consecutive rising edges; optional overflow tracking.
  task automatic write_vec(input int n, input bit chk_ovf);
    for (int i = 0; i < n; i++) begin
      fxp_data_i       = vec[i];
      fxp_data_valid_i = 1'b1;
      @(negedge clock_i);
      if (chk_ovf) begin
        n_cmp++;
        if (overflow_o !== (i >= 10)) begin
          n_fail++;
          $display("FAIL overflow_w%0d: got %b want %b", i, overflow_o, (i >= 10));
        end
      end
    end
    fxp_data_valid_i = 1'b0;
  endtask

  // Waits (bounded) for a valid result; with ready=1 it is consumed on the next edge.
  task automatic get_result(output logic [31:0] d, output bit ok);
    ok = 1'b0;
    d  = 32'h0;
    for (int k = 0; k < 40; k++) begin
      if (fp_data_valid_o === 1'b1) begin
        d  = fp_data_o;
        ok = 1'b1;
        @(negedge clock_i);
        return;
      end
      @(negedge clock_i);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (fp_data_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", fp_data_valid_o); end
    n_cmp++; if (fp_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", fp_data_o); end
    n_cmp++; if (fp_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", fp_done_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
  endtask

  task automatic test_single();
    do_reset();
    fxp_data_i       = 32'h0001_0000;
    fxp_data_valid_i = 1'b1;
    @(negedge clock_i);
    fxp_data_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (fp_data_valid_o !== (k == 3)) begin
        n_fail++;
        $display("FAIL single_latency_c%0d: got valid %b want %b", k, fp_data_valid_o, (k == 3));
      end
      if (k == 3) begin
        n_cmp++;
        if (fp_data_o !== 32'h3F80_0000) begin
          n_fail++;
          $display("FAIL single_data: got %h want 3f800000", fp_data_o);
        end
      end
      @(negedge clock_i);
    end
    n_cmp++;
    if (fp_data_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_consumed: got valid %b want 0", fp_data_valid_o); end
  endtask

  task automatic test_patterns();
    logic [31:0] d;
    bit ok;
    do_reset();
    vec[0] = 32'h0001_8000; exp_vec[0] = 32'h3FC0_0000;
    vec[1] = 32'h0000_0001; exp_vec[1] = 32'h3780_0000;
    vec[2] = 32'hFFFF_FFFF; exp_vec[2] = 32'h477F_FFFF;
    vec[3] = 32'h0000_0000; exp_vec[3] = 32'h0000_0000;
    write_vec(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      get_result(d, ok);
      n_cmp++;
      if (!ok || d !== exp_vec[i]) begin
        n_fail++;
        $display("FAIL pattern_%0d: got %h (seen %b) want %h", i, d, ok, exp_vec[i]);
      end
    end
    n_cmp++;
    if (fp_done_o !== 1'b0) begin n_fail++; $display("FAIL pattern_done: got %b want 0", fp_done_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    bit ok;
    bit seen;
    do_reset();
    fp_data_ready_i = 1'b0;
    vec[0] = 32'h0001_8000;
    vec[1] = 32'h0001_0000;
    write_vec(2, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (fp_data_valid_o === 1'b1) seen = 1'b1;
      else @(negedge clock_i);
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL bp_first_valid: got timeout want valid"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (fp_data_valid_o !== 1'b1 || fp_data_o !== 32'h3FC0_0000) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: got valid %b data %h want 1 3fc00000", k, fp_data_valid_o, fp_data_o);
      end
      @(negedge clock_i);
    end
    fp_data_ready_i = 1'b1;
    @(negedge clock_i);
    n_cmp++;
    if (fp_data_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release: got valid %b want 0", fp_data_valid_o); end
    get_result(d, ok);
    n_cmp++;
    if (!ok || d !== 32'h3F80_0000) begin
      n_fail++;
      $display("FAIL bp_second: got %h (seen %b) want 3f800000", d, ok);
    end
  endtask

  task automatic load_integers();
    vec[0] = 32'h0001_0000; exp_vec[0] = 32'h3F80_0000;
    vec[1] = 32'h0002_0000; exp_vec[1] = 32'h4000_0000;
    vec[2] = 32'h0003_0000; exp_vec[2] = 32'h4040_0000;
    vec[3] = 32'h0004_0000; exp_vec[3] = 32'h4080_0000;
    vec[4] = 32'h0005_0000; exp_vec[4] = 32'h40A0_0000;
    vec[5] = 32'h0006_0000; exp_vec[5] = 32'h40C0_0000;
    vec[6] = 32'h0007_0000; exp_vec[6] = 32'h40E0_0000;
    vec[7] = 32'h0008_0000; exp_vec[7] = 32'h4100_0000;
    vec[8] = 32'h0009_0000; exp_vec[8] = 32'h4110_0000;
    vec[9] = 32'h000A_0000; exp_vec[9] = 32'h4120_0000;
    vec[10] = 32'h0064_0000; exp_vec[10] = 32'h42C8_0000;
  endtask

  task automatic collect_vec(input string tag);
    logic [31:0] d;
    bit ok;
    for (int i = 0; i < 10; i++) begin
      get_result(d, ok);
      n_cmp++;
      if (!ok || d !== exp_vec[i]) begin
        n_fail++;
        $display("FAIL %s_r%0d: got %h (seen %b) want %h", tag, i, d, ok, exp_vec[i]);
      end
    end
    @(negedge clock_i);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (fp_done_o !== 1'b1 || fp_data_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_done_c%0d: got done %b valid %b want 1 0", tag, k, fp_done_o, fp_data_valid_o);
      end
      @(negedge clock_i);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_integers();
    fork
      write_vec(10, 1'b0);
      collect_vec("b2b");
    join
    n_cmp++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", overflow_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    load_integers();
    fork
      write_vec(11, 1'b1);
      collect_vec("ovf");
    join
    n_cmp++;
    if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit ok;
    bit seen;
    do_reset();
    load_integers();
    fork
      write_vec(10, 1'b0);
      for (int i = 0; i < 3; i++) get_result(d, ok);
    join
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (fp_data_valid_o === 1'b1) seen = 1'b1;
      else @(negedge clock_i);
    end
    n_cmp++;
    if (!seen || fp_data_o !== 32'h4080_0000) begin
      n_fail++;
      $display("FAIL mid_r3: got %h (seen %b) want 40800000", fp_data_o, seen);
    end
    reset_i         = 1'b1;
    fp_data_ready_i = 1'b0;
    @(negedge clock_i);
    n_cmp++;
    if (fp_data_valid_o !== 1'b0 || fp_data_o !== 32'h0 || fp_done_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid %b data %h done %b ovf %b want all 0",
               fp_data_valid_o, fp_data_o, fp_done_o, overflow_o);
    end
    reset_i         = 1'b0;
    fp_data_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (fp_data_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_no_partial_c%0d: got valid %b want 0", k, fp_data_valid_o);
      end
      @(negedge clock_i);
    end
    vec[0] = 32'h0001_8000; exp_vec[0] = 32'h3FC0_0000;
    vec[1] = 32'h0002_8000; exp_vec[1] = 32'h4020_0000;
    vec[2] = 32'h0003_8000; exp_vec[2] = 32'h4060_0000;
    vec[3] = 32'h0004_8000; exp_vec[3] = 32'h4090_0000;
    vec[4] = 32'h0005_8000; exp_vec[4] = 32'h40B0_0000;
    vec[5] = 32'h0006_8000; exp_vec[5] = 32'h40D0_0000;
    vec[6] = 32'h0007_8000; exp_vec[6] = 32'h40F0_0000;
    vec[7] = 32'h0008_8000; exp_vec[7] = 32'h4108_0000;
    vec[8] = 32'h0009_8000; exp_vec[8] = 32'h4118_0000;
    vec[9] = 32'h000A_8000; exp_vec[9] = 32'h4128_0000;
    fork
      write_vec(10, 1'b0);
      collect_vec("mid_new");
    join
  endtask

  initial begin
    reset_i          = 1'b1;
    fxp_data_i       = 32'h0;
    fxp_data_valid_i = 1'b0;
    fp_data_ready_i  = 1'b1;
    @(negedge clock_i);
    test_reset();
    test_single();
    test_patterns();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
